barrel_normalizer: RTL and testbench
====================================

Name: barrel_normalizer

Overview:
Iterative leading-one normalizer. It is the inverse companion of the logarithmic shifter: the shifter takes data plus a shift amount and produces shifted data; this block takes raw data and derives the left-shift amount that moves the most-significant 1 to bit nBits-1. It processes one power-of-two stage per clock, largest stage first. It uses a valid/ready handshake on both sides and feeds the floating-point/fixed-point normalization paths.

Parameters:
nShifts, 3, number of shift stages and width of out_count; stage k tests and shifts by 2^k.
nBits, 8, data width; legal range 2^(nShifts-1) < nBits <= 2^nShifts.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_data  input  nBits  value to normalize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a new input
out_data  output  nBits  normalized value (MSB = 1 unless zero)
out_count  output  nShifts  left-shift amount applied
out_zero  output  1  in_data was all zeros
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result

Behaviour:
- Clocking: single clock clk. Reset reset_n is asynchronous and active-low.
- Reset: state IDLE, stage index = nShifts-1, working data/count = 0. Outputs: in_ready=1, out_valid=0, out_data=0, out_count=0, out_zero=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, the input is accepted: latch in_data, clear count, set stage index k=nShifts-1, go to RUN.
- RUN (in_ready=0):
  - Each cycle evaluates stage k on the working register.
  - If the top min(2^k, nBits) bits are all zero: working <= working << 2^k (zero-fill), count[k] <= 1. Otherwise both are unchanged.
  - If k=0, go to DONE; otherwise k <= k-1.
- DONE:
  - out_valid=1. out_data, out_count and out_zero are held stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready, go to IDLE.
  - in_ready=0 in DONE. There is no accept-on-drain.
- Latency: input accepted at edge N; out_valid is high after edge N+nShifts. Peak throughput is one result per nShifts+2 cycles.
- Zero input: out_zero=1, out_data=0, out_count forced to 0 (not the all-ones stage accumulation).
- Already-normalized input (MSB=1): out_data=in_data, out_count=0.
- Non-power-of-two nBits: a stage with 2^k >= nBits shifts only if all bits are zero. The zero case is overridden as above. Resulting out_count is always <= nBits-1.
- Handshake rules:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - in_valid/in_data need not be held after acceptance.
- Reset mid-operation: reset_n low in any state immediately clears out_valid and the outputs, and discards the in-flight value. After deassertion the block is in IDLE with in_ready=1.
- Invariant: logical right shift of out_data by out_count equals the accepted in_data (for nonzero input).
- Width rules: all shifts are logical, zero-filled, truncated to nBits. out_count bit k corresponds to a shift by 2^k.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE) and a helper function for the stage test width min(2^k, nBits). These are shared with the shifter bench.
- Sub-module barrel_norm_stage (combinational):
  - Parameters nBits and stage width; runtime stage index.
  - Returns the shifted data and the stage-taken flag.
  - Instantiated once and reused every RUN cycle.
- The top level holds the FSM, working register, count register and handshake logic.

Test Plan:
- nBits=8,nShifts=3: in_data=0x01 accepted at edge N -> out_valid at edge N+3, out_data=0x80, out_count=7, out_zero=0.
- in_data=0x13 -> out_data=0x98, out_count=3. in_data=0x80 -> out_data=0x80, out_count=0.
- in_data=0x00 -> out_data=0x00, out_count=0, out_zero=1.
- Backpressure with in_data=0x13: hold out_ready=0 for 5 cycles while driving in_valid=1, in_data=0x40. Outputs stay 0x98/3 and in_ready=0. Release -> IDLE, then 0x40 is accepted -> out_data=0x80, out_count=1.
- Assert reset_n=0 during RUN -> out_valid=0 and outputs 0 within the same cycle. After release, in_ready=1 and a fresh 0x02 -> out_data=0x80, out_count=6.
- nBits=6,nShifts=3: in_data=0x01 -> out_data=0x20, out_count=5. Random sweep checks the right-shift invariant against an independent reference model.

Source files
------------

// File: rtl/barrel_normalizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : barrel_normalizer_pkg
// Description : State encoding and stage helpers for the leading-one normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
package barrel_normalizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } norm_state_e;

    // Number of top bits examined by stage k: min(2^k, nbits).
    function automatic int stage_width(input int k, input int nbits);
        return ((1 << k) < nbits) ? (1 << k) : nbits;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_norm_stage.sv
`default_nettype none
// ============================================================================
// Module      : barrel_norm_stage
// Description : One normalizer stage; shifts left by 2^k when the top bits are clear.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_norm_stage
    import barrel_normalizer_pkg::*;
#(
    parameter int nBits = 8,
    parameter int KW    = 2
) (
    input  logic [nBits-1:0] i_data,
    input  logic [KW-1:0]    i_k,
    output logic [nBits-1:0] o_data,
    output logic             o_taken
);

    int   w_width;
    int   w_shamt;
    logic w_any_one;

    always_comb begin
        w_width   = stage_width(int'(i_k), nBits);
        w_shamt   = 1 << i_k;
        w_any_one = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            if ((i >= nBits - w_width) && i_data[i]) begin
                w_any_one = 1'b1;
            end
        end
        o_taken = ~w_any_one;
        o_data  = o_taken ? (i_data << w_shamt) : i_data;
    end

endmodule
`default_nettype wire

// File: rtl/barrel_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : barrel_normalizer
// Description : Iterative leading-one normalizer, one power-of-two stage per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_normalizer
    import barrel_normalizer_pkg::*;
#(
    parameter int nShifts = 3,
    parameter int nBits   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [nBits-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [nBits-1:0]   out_data,
    output logic [nShifts-1:0] out_count,
    output logic               out_zero,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int          KW    = idx_width(nShifts);
    localparam logic [KW-1:0] K_TOP = KW'(nShifts - 1);

    norm_state_e          state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [nBits-1:0]     work_q, work_d;
    logic [nShifts-1:0]   count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [nBits-1:0]     out_data_q, out_data_d;
    logic [nShifts-1:0]   out_count_q, out_count_d;
    logic                 out_zero_q, out_zero_d;

    logic [nBits-1:0]     w_stage_data;
    logic                 w_taken;
    logic [nBits-1:0]     w_work_next;
    logic [nShifts-1:0]   w_count_next;
    logic                 w_zero;

    barrel_norm_stage #(
        .nBits (nBits),
        .KW    (KW)
    ) u_stage (
        .i_data  (work_q),
        .i_k     (k_q),
        .o_data  (w_stage_data),
        .o_taken (w_taken)
    );

    always_comb begin
        w_work_next  = w_taken ? w_stage_data : work_q;
        w_count_next = count_q | (nShifts'(w_taken) << k_q);
        w_zero       = (w_work_next == '0);

        state_d     = state_q;
        k_d         = k_q;
        work_d      = work_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_RUN;
                    work_d     = in_data;
                    count_d    = '0;
                    k_d        = K_TOP;
                    in_ready_d = 1'b0;
                end
            end
            ST_RUN: begin
                work_d  = w_work_next;
                count_d = w_count_next;
                if (k_q == '0) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = w_work_next;
                    // A zero input takes every stage; report no shift instead.
                    out_count_d = w_zero ? '0 : w_count_next;
                    out_zero_d  = w_zero;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= K_TOP;
            work_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            work_q      <= work_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_zero  = out_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_normalizer
// Description : Directed and swept checks for barrel_normalizer at nBits 8 and 6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_normalizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;

    logic [7:0] a_in_data;
    logic       a_in_valid, a_in_ready;
    logic [7:0] a_out_data;
    logic [2:0] a_out_count;
    logic       a_out_zero, a_out_valid, a_out_ready;

    logic [5:0] b_in_data;
    logic       b_in_valid, b_in_ready;
    logic [5:0] b_out_data;
    logic [2:0] b_out_count;
    logic       b_out_zero, b_out_valid, b_out_ready;

    barrel_normalizer #(.nShifts(3), .nBits(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_count(a_out_count), .out_zero(a_out_zero),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    barrel_normalizer #(.nShifts(3), .nBits(6)) dut6 (
        .clk(clk), .reset_n(reset_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_count(b_out_count), .out_zero(b_out_zero),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic [2:0] exp_count;
        logic       exp_zero;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // sel=0 drives the 8-bit instance, sel=1 the 6-bit instance.
    task automatic start_xact(input bit sel, input logic [7:0] din);
        int n = 0;
        while (((sel ? b_in_ready : a_in_ready) !== 1'b1) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_accept", {31'd0, sel ? b_in_ready : a_in_ready}, 32'd1);
        if (sel) begin b_in_valid = 1'b1; b_in_data = din[5:0]; end
        else     begin a_in_valid = 1'b1; a_in_data = din;      end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_result(input bit sel, input string tag,
                               output logic [7:0] od, output logic [2:0] oc, output logic oz);
        int lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1; lat++;
            if ((sel ? b_out_valid : a_out_valid) === 1'b1) break;
        end
        check({tag, "_latency"}, lat, 32'd3);
        od = sel ? {2'b00, b_out_data} : a_out_data;
        oc = sel ? b_out_count : a_out_count;
        oz = sel ? b_out_zero  : a_out_zero;
    endtask

    task automatic drain(input bit sel);
        if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] od;
        logic [2:0] oc;
        logic       oz;

        vecs[0] = '{8'h01, 8'h80, 3'd7, 1'b0};
        vecs[1] = '{8'h13, 8'h98, 3'd3, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 3'd0, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 3'd0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 3'd0, 1'b0};
        vecs[5] = '{8'h0F, 8'hF0, 3'd4, 1'b0};
        vecs[6] = '{8'h20, 8'h80, 3'd2, 1'b0};
        vecs[7] = '{8'h03, 8'hC0, 3'd6, 1'b0};

        reset_n     = 1'b0;
        a_in_data   = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_data   = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        #12;
        check("reset_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("reset_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("reset_out_data",  {24'd0, a_out_data},  32'd0);
        check("reset_out_count", {29'd0, a_out_count}, 32'd0);
        check("reset_out_zero",  {31'd0, a_out_zero},  32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            start_xact(1'b0, vecs[i].din);
            wait_result(1'b0, "vec", od, oc, oz);
            check("vec_data",  {24'd0, od}, {24'd0, vecs[i].exp_data});
            check("vec_count", {29'd0, oc}, {29'd0, vecs[i].exp_count});
            check("vec_zero",  {31'd0, oz}, {31'd0, vecs[i].exp_zero});
            drain(1'b0);
        end

        // Backpressure: result must hold while in_valid is offered and ignored.
        start_xact(1'b0, 8'h13);
        wait_result(1'b0, "bp", od, oc, oz);
        a_in_valid = 1'b1;
        a_in_data  = 8'h40;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, a_out_valid}, 32'd1);
            check("bp_hold_data",  {24'd0, a_out_data},  32'h98);
            check("bp_hold_count", {29'd0, a_out_count}, 32'd3);
            check("bp_hold_ready", {31'd0, a_in_ready},  32'd0);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check("bp_release_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, a_out_valid}, 32'd0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        wait_result(1'b0, "bp2", od, oc, oz);
        check("bp2_data",  {24'd0, od}, 32'h80);
        check("bp2_count", {29'd0, oc}, 32'd1);
        drain(1'b0);

        // Asynchronous reset in the middle of RUN.
        start_xact(1'b0, 8'h13);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, a_out_data},  32'd0);
        check("rst_out_count", {29'd0, a_out_count}, 32'd0);
        check("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_after_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("rst_after_out_valid", {31'd0, a_out_valid}, 32'd0);
        start_xact(1'b0, 8'h02);
        wait_result(1'b0, "post_rst", od, oc, oz);
        check("post_rst_data",  {24'd0, od}, 32'h80);
        check("post_rst_count", {29'd0, oc}, 32'd6);
        drain(1'b0);

        // Non-power-of-two width.
        start_xact(1'b1, 8'h01);
        wait_result(1'b1, "n6_one", od, oc, oz);
        check("n6_one_data",  {24'd0, od}, 32'h20);
        check("n6_one_count", {29'd0, oc}, 32'd5);
        drain(1'b1);

        start_xact(1'b1, 8'h00);
        wait_result(1'b1, "n6_zero", od, oc, oz);
        check("n6_zero_data",  {24'd0, od}, 32'd0);
        check("n6_zero_count", {29'd0, oc}, 32'd0);
        check("n6_zero_flag",  {31'd0, oz}, 32'd1);
        drain(1'b1);

        for (int r = 0; r < 16; r++) begin
            logic [5:0] din;
            logic [5:0] exp_d;
            int         lz;
            din = 6'($urandom_range(1, 63));
            lz  = 6;
            for (int b = 5; b >= 0; b--) begin
                if (din[b] && lz == 6) lz = 5 - b;
            end
            exp_d = din << lz;
            start_xact(1'b1, {2'b00, din});
            wait_result(1'b1, "n6_rand", od, oc, oz);
            check("n6_rand_data",  {24'd0, od}, {26'd0, exp_d});
            check("n6_rand_count", {29'd0, oc}, lz);
            check("n6_rand_invariant", {26'd0, od[5:0] >> oc}, {26'd0, din});
            check("n6_rand_zero",  {31'd0, oz}, 32'd0);
            drain(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
